// File: rtl/bnn_pkg.sv
// Shared constants for the BNN weight path: kernel geometry, BRAM address width,
// default read latency and the weight fetch FSM state encoding.
package bnn_pkg;

    localparam int unsigned KW         = 5;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned RD_LAT_DEF = 1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_HOLD  = 2'd3;

    // Column counter must reach KW after the final issue cycle.
    function automatic int unsigned cnt_width(input int unsigned kw);
        return $clog2(kw + 1);
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// RD_LAT-stage 1-bit delay line. It realigns the BRAM read enable with returning data.
// The flush input empties the line so that an aborted fetch produces no late shift pulses.
module rd_lat_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic din_i,
    output logic load_o,
    output logic pending_c_o
);

    // Every stage except the output stage; a set bit means more pulses are still coming.
    localparam logic [RD_LAT-1:0] EARLY_MASK = {RD_LAT{1'b1}} >> 1;

    logic [RD_LAT-1:0] pipe_q;
    logic [RD_LAT-1:0] pipe_d;

    // Shift toward the MSB, or clear the whole line on flush.
    always_comb begin
        pipe_d = (pipe_q << 1) | RD_LAT'(din_i);
        if (flush_i) begin
            pipe_d = '0;
        end
    end

    // Delay line storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign load_o      = pipe_q[RD_LAT-1];
    assign pending_c_o = |(pipe_q & EARLY_MASK);

endmodule

// File: rtl/weight_bram_reader.sv
// Fetch-side master for the weight preload shift register. It reads KW consecutive
// BRAM columns from a base address and emits one preload shift per returned column.
// It then holds weight_valid until the ALU consumes the kernel.
module weight_bram_reader
    import bnn_pkg::*;
#(
    parameter int unsigned ADDR_W = bnn_pkg::ADDR_W,
    parameter int unsigned KW     = bnn_pkg::KW,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              load_weight_preload,
    output logic              weight_valid,
    input  logic              weight_consume,
    output logic              busy,
    output logic              start_err
);

    localparam int unsigned CNT_W = cnt_width(KW);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en_q, en_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              load;
    logic              pending;
    logic              last_col;

    assign last_col = (cnt_q == CNT_W'(KW - 1));

    // Read enable delayed by the BRAM latency becomes the preload shift enable.
    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (clear),
        .din_i       (en_q),
        .load_o      (load),
        .pending_c_o (pending)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear overrides every other request.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start)             state_d = S_ISSUE;
                S_ISSUE: if (last_col)          state_d = S_DRAIN;
                S_DRAIN: if (load && !pending)  state_d = S_HOLD;
                S_HOLD:  if (weight_consume)    state_d = S_IDLE;
                default:                        state_d = S_IDLE;
            endcase
        end
    end

    // Next output/datapath values. Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        cnt_d   = cnt_q;
        base_d  = base_q;
        addr_d  = addr_q;
        en_d    = (state_d == S_ISSUE);
        valid_d = (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
        err_d   = start && (state_q != S_IDLE) && !clear;
        if (!clear) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_d = base_addr;
                        cnt_d  = '0;
                        addr_d = base_addr;
                    end
                end
                S_ISSUE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!last_col) begin
                        addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bram_en             = en_q;
    assign bram_addr           = addr_q;
    assign load_weight_preload = load;
    assign weight_valid        = valid_q;
    assign busy                = busy_q;
    assign start_err           = err_q;

endmodule

// File: tb/tb_weight_bram_reader.sv
// Bench for weight_bram_reader. Three instances share one stimulus stream, with RD_LAT set to 1, 2 and 3.
// Each instance is compared every cycle against a fetch-timeline model.
module tb_weight_bram_reader;

    localparam int KWT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic       weight_consume;
    logic [9:0] base_addr;

    logic       en_w    [3];
    logic [9:0] addr_w  [3];
    logic       load_w  [3];
    logic       valid_w [3];
    logic       busy_w  [3];
    logic       err_w   [3];

    // Reference model: per instance, whether a fetch is live, its start cycle and base address.
    bit         m_act  [3];
    int         m_t    [3];
    logic [9:0] m_base [3];
    logic [9:0] m_addr [3];
    bit         m_err  [3];

    int cyc;
    int errors;
    int checks;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        weight_bram_reader #(
            .ADDR_W (10),
            .KW     (5),
            .RD_LAT (g + 1)
        ) dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .start               (start),
            .base_addr           (base_addr),
            .clear               (clear),
            .bram_en             (en_w[g]),
            .bram_addr           (addr_w[g]),
            .load_weight_preload (load_w[g]),
            .weight_valid        (valid_w[g]),
            .weight_consume      (weight_consume),
            .busy                (busy_w[g]),
            .start_err           (err_w[g])
        );
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat=%0d cyc=%0d got=%0h exp=%0h", tag, k + 1, cyc, obs, exp);
        end
    endtask

    // Expected outputs come from position within the fetch: enable on rel 1..KW,
    // load on rel L+1..L+KW, valid from rel KW+L+1.
    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int rel;
            int lat;
            bit e_en;
            bit e_ld;
            bit e_vl;
            rel  = cyc - m_t[k];
            lat  = k + 1;
            e_en = m_act[k] && rel >= 1 && rel <= KWT;
            e_ld = m_act[k] && rel >= lat + 1 && rel <= lat + KWT;
            e_vl = m_act[k] && rel >= KWT + lat + 1;
            if (e_en) m_addr[k] = m_base[k] + 10'(rel - 1);
            chk("bram_en",   k, 32'(en_w[k]),    32'(e_en));
            chk("bram_addr", k, 32'(addr_w[k]),  32'(m_addr[k]));
            chk("load",      k, 32'(load_w[k]),  32'(e_ld));
            chk("valid",     k, 32'(valid_w[k]), 32'(e_vl));
            chk("busy",      k, 32'(busy_w[k]),  32'(m_act[k]));
            chk("start_err", k, 32'(err_w[k]),   32'(m_err[k]));
        end
    endtask

    // Advance the model by the request rules, then clock the DUTs and compare.
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            bit busy_now;
            bit valid_now;
            busy_now  = m_act[k];
            valid_now = m_act[k] && (cyc - m_t[k]) >= KWT + k + 2;
            m_err[k]  = start && busy_now && !clear;
            if (clear) begin
                m_act[k] = 1'b0;
            end else if (!busy_now && start) begin
                m_act[k]  = 1'b1;
                m_t[k]    = cyc;
                m_base[k] = base_addr;
            end else if (valid_now && weight_consume) begin
                m_act[k] = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic fetch(input logic [9:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
    endtask

    task automatic consume1();
        weight_consume = 1'b1;
        tick();
        weight_consume = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_act[k]  = 1'b0;
            m_t[k]    = 0;
            m_base[k] = '0;
            m_addr[k] = '0;
            m_err[k]  = 1'b0;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        start          = 1'b0;
        clear          = 1'b0;
        weight_consume = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        cyc            = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        clear          = 1'b0;
        weight_consume = 1'b0;
        base_addr      = '0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // Basic fetch from 0x010.
        fetch(10'h010);
        run(12);
        consume1();
        run(2);

        // Address wrap past the top of the BRAM.
        fetch(10'h3FE);
        run(12);
        consume1();
        run(2);

        // Start during ISSUE and during HOLD is rejected with start_err.
        fetch(10'h123);
        run(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        run(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        run(1);
        consume1();
        run(1);

        // Consume while idle has no effect.
        weight_consume = 1'b1;
        run(3);
        weight_consume = 1'b0;
        run(1);

        // Start together with consume in HOLD: consume is taken and the start is flagged.
        fetch(10'h200);
        run(12);
        start          = 1'b1;
        weight_consume = 1'b1;
        tick();
        start          = 1'b0;
        weight_consume = 1'b0;
        run(3);

        // Clear on the third ISSUE cycle, then a clean refetch.
        fetch(10'h055);
        run(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        run(3);
        fetch(10'h056);
        run(12);
        consume1();
        run(2);

        // Asynchronous reset during DRAIN, then nominal fetch.
        fetch(10'h0AA);
        run(5);
        async_reset();
        fetch(10'h0AB);
        run(12);
        consume1();
        run(2);

        // Random request mix.
        repeat (400) begin
            start          = ($urandom % 5 == 0);
            clear          = ($urandom % 30 == 0);
            weight_consume = ($urandom % 4 == 0);
            base_addr      = 10'($urandom);
            tick();
        end
        start          = 1'b0;
        weight_consume = 1'b0;
        clear          = 1'b1;
        tick();
        clear = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
